pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Hazard and stall controller for the 5-stage pipeline. It drives the `pause` and `branch_signal` inputs of the IF/ID register and the PC, and the bubble input of the ID/EX register. It detects load-use hazards, sequences multi-cycle multiply/divide stalls with an internal FSM and counter, and gates branch flushes. Two saturating performance counters record stall cycles and flushes.

## Interface
- `MDU_CYCLES`, 32: total pause cycles per multiply/divide issue; legal range ≥ 2.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `id_rs`, `id_rt` in 5 each: source register numbers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1 each: ID instruction actually reads `rs` / `rt`.
- `id_is_mdu` in 1: ID instruction is a mult/div needing the multi-cycle unit.
- `ex_is_load` in 1: EX-stage instruction is a load.
- `ex_rd` in 5: destination register of the EX instruction.
- `branch_taken` in 1: branch in ID resolved taken this cycle.
- `pause` out 1: hold PC and IF/ID.
- `branch_signal` out 1: flush IF/ID (zero `npc` and instruction).
- `idex_bubble` out 1: load a NOP into ID/EX.
- `mdu_start` out 1: one-cycle start pulse to the multiply/divide unit.
- `mdu_busy` out 1: FSM is in `MDU_WAIT`.
- `stall_cycles` out `CNT_W`: count of cycles with `pause`=1.
- `flush_count` out `CNT_W`: count of cycles with `branch_signal`=1.

## Operation
- `load_hz` = `ex_is_load` & (`ex_rd`≠0) & ((`id_uses_rs` & `id_rs`==`ex_rd`) | (`id_uses_rt` & `id_rt`==`ex_rd`)).
- FSM states:
  - `IDLE`:
    - if `load_hz`: `pause`=1, stay in `IDLE`.
    - else if `id_is_mdu`: `pause`=1 and `mdu_start`=1, load `cnt`=`MDU_CYCLES`−1, go to `MDU_WAIT`.
    - else `pause`=0.
  - `MDU_WAIT`: `pause`=1 and `mdu_busy`=1. `cnt` decrements each cycle. When `cnt`==1, go to `RELEASE`.
  - `RELEASE`: `pause`=0. `id_is_mdu` is ignored so the same instruction does not re-issue. Go to `IDLE`.
- Priority: `load_hz` beats MDU issue. A mult/div with a load-use hazard stalls one cycle, then issues.
- `idex_bubble` = `pause`.
- `branch_signal` = `branch_taken` & ~`pause`.
  - The IF/ID register ignores flush while paused, so a branch behind a load-use stall flushes only on its unstalled cycle.
  - `branch_taken` is ignored throughout `MDU_WAIT`.
- `mdu_start` is asserted only on the `IDLE`→`MDU_WAIT` transition cycle.
- Counters:
  - `stall_cycles` increments on each edge where `pause`=1.
  - `flush_count` increments on each edge where `branch_signal`=1.
  - Both saturate at all-ones and never wrap.
- Reset:
  - On any edge with `reset`=1: state←`IDLE`, `cnt`←0, both counters←0.
  - While `reset`=1, all combinational outputs are forced to 0.
  - Reset mid-`MDU_WAIT` abandons the stall with no `RELEASE` cycle.

## Timing
- `pause`, `branch_signal`, `idex_bubble` and `mdu_start` are combinational from the current state and inputs. They are valid in the same cycle as the hazard, with zero latency.
- A load-use stall lasts exactly 1 cycle, because the load advances to MEM and `load_hz` drops.
- An MDU issue gives exactly `MDU_CYCLES` consecutive `pause` cycles (1 in `IDLE` + `MDU_CYCLES`−1 in `MDU_WAIT`), then one `RELEASE` cycle with `pause`=0.
- `mdu_busy` is registered state: it rises on the edge after `mdu_start` and falls on the edge entering `RELEASE`.
- Counter outputs are registered and reflect events up to the previous edge.

## Structure
- A shared pipeline package holds:
  - the FSM state enum (`IDLE`, `MDU_WAIT`, `RELEASE`);
  - the register-zero constant 5'd0;
  - the default `MDU_CYCLES`.
- Sub-module `sat_counter` (parameter `CNT_W`; inputs `clock`, `reset`, `inc`; output `value`) is instantiated twice, once per performance counter.
- The hazard compare and the FSM stay in the top module.

## Test plan
- Load-use hazard: `ex_is_load`=1, `ex_rd`=5, `id_rs`=5, `id_uses_rs`=1 for one cycle.
  - Required: `pause`=`idex_bubble`=1 for exactly 1 cycle; `stall_cycles`=1.
- No hazard on register 0: the load-use setup with `ex_rd`=0 and `id_rs`=0.
  - Required: `pause`=0; counters unchanged.
- MDU issue: `id_is_mdu`=1 held with `MDU_CYCLES`=4.
  - Required: `mdu_start` pulses once; `pause`=1 for 4 cycles; `mdu_busy`=1 for 3; then the `RELEASE` cycle has `pause`=0; `stall_cycles`=4.
- Branch gating:
  - `branch_taken`=1 with no hazard → `branch_signal`=1 and `flush_count`=1.
  - `branch_taken`=1 together with `load_hz` → `branch_signal`=0 in the stall cycle and 1 in the next cycle.
- Reset during an MDU stall: assert `reset` in the 2nd `MDU_WAIT` cycle.
  - Required: the next cycle is `IDLE` with all outputs 0 and both counters 0.
- Saturation: with `CNT_W`=3, hold a stall condition for 10 cycles.
  - Required: `stall_cycles` stops at 7.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared pipeline definitions: hazard FSM states, register-zero constant and
// the default multiply/divide stall length.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MDU_WAIT = 2'd1,
    RELEASE  = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MDU_CYCLES_DEFAULT = 32;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating event counter: counts cycles with inc=1 and holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_r;

  // Count events, sticking at the maximum rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_r <= {CNT_W{1'b0}};
    end else if (inc && (value_r != {CNT_W{1'b1}})) begin
      value_r <= value_r + CNT_W'(1);
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Load-use / multiply-divide stall controller with branch flush gating and
// saturating stall and flush performance counters.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MDU_CYCLES = MDU_CYCLES_DEFAULT,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_mdu,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  output logic             pause,
  output logic             branch_signal,
  output logic             idex_bubble,
  output logic             mdu_start,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int CW = $clog2(MDU_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  hz_state_t     state_r;
  logic [CW-1:0] cnt_r;
  logic          mdu_busy_r;
  logic          load_hz_s;
  logic          pause_s;
  logic          start_s;
  logic          branch_s;

  assign load_hz_s = ex_is_load & (ex_rd != REG_ZERO) &
                     ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  // Zero-latency stall and issue decode; a load-use hazard wins over MDU issue.
  always_comb begin
    pause_s = 1'b0;
    start_s = 1'b0;
    if (reset) begin
      pause_s = 1'b0;
      start_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_hz_s) begin
            pause_s = 1'b1;
          end else if (id_is_mdu) begin
            pause_s = 1'b1;
            start_s = 1'b1;
          end else begin
            pause_s = 1'b0;
          end
        end
        MDU_WAIT: pause_s = 1'b1;
        RELEASE:  pause_s = 1'b0;
        default:  pause_s = 1'b0;
      endcase
    end
  end

  // A flush is only honoured on an unstalled cycle.
  always_comb begin
    if (reset) begin
      branch_s = 1'b0;
    end else begin
      branch_s = branch_taken & ~pause_s;
    end
  end

  // Stall sequencer; RELEASE gives the held mult/div one cycle to leave ID.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      mdu_busy_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r    <= MDU_WAIT;
            cnt_r      <= CNT_LOAD;
            mdu_busy_r <= 1'b1;
          end else begin
            state_r    <= IDLE;
            mdu_busy_r <= 1'b0;
          end
        end
        MDU_WAIT: begin
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r    <= RELEASE;
            mdu_busy_r <= 1'b0;
          end else begin
            state_r    <= MDU_WAIT;
            mdu_busy_r <= 1'b1;
          end
        end
        RELEASE: begin
          state_r    <= IDLE;
          mdu_busy_r <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= {CW{1'b0}};
          mdu_busy_r <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (pause_s),
    .value (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (branch_s),
    .value (flush_count)
  );

  assign pause         = pause_s;
  assign idex_bubble   = pause_s;
  assign mdu_start     = start_s;
  assign branch_signal = branch_s;
  assign mdu_busy      = mdu_busy_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios plus random traffic
// against a stall-budget model; two instances cover 8-bit and 3-bit counters.
module tb_pipeline_hazard_controller;

  localparam int MDU = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, id_is_mdu, ex_is_load, branch_taken;

  logic       pause, branch_signal, idex_bubble, mdu_start, mdu_busy;
  logic [7:0] stall_cycles, flush_count;
  logic       s3_pause, s3_branch, s3_bubble, s3_start, s3_busy;
  logic [2:0] s3_stall, s3_flush;

  int total  = 0;
  int passed = 0;

  // reference model: remaining MDU pause cycles after the issue cycle
  int m_left  = 0;
  bit m_rel   = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  logic s_pause, s_bubble, s_start, s_busy, s_branch;
  logic [4:0] pat_p, pat_s, pat_b;

  pipeline_hazard_controller #(.MDU_CYCLES(MDU), .CNT_W(8)) u_dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_mdu(id_is_mdu),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .pause(pause), .branch_signal(branch_signal), .idex_bubble(idex_bubble),
    .mdu_start(mdu_start), .mdu_busy(mdu_busy),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipeline_hazard_controller #(.MDU_CYCLES(MDU), .CNT_W(3)) u_sat (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_mdu(id_is_mdu),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .pause(s3_pause), .branch_signal(s3_branch), .idex_bubble(s3_bubble),
    .mdu_start(s3_start), .mdu_busy(s3_busy),
    .stall_cycles(s3_stall), .flush_count(s3_flush)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic clear();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_mdu = 1'b0;
    ex_is_load = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic rand_inputs();
    reset        = ($urandom_range(0, 63) == 0);
    ex_is_load   = 1'($urandom_range(0, 1));
    ex_rd        = 5'($urandom_range(0, 3));
    id_rs        = 5'($urandom_range(0, 3));
    id_rt        = 5'($urandom_range(0, 3));
    id_uses_rs   = 1'($urandom_range(0, 1));
    id_uses_rt   = 1'($urandom_range(0, 1));
    id_is_mdu    = ($urandom_range(0, 5) == 0);
    branch_taken = ($urandom_range(0, 2) == 0);
  endtask

  // one clock cycle: compare at the falling edge, advance the model at the rising edge
  task automatic step();
    bit hz, e_pause, e_start, e_busy, e_branch;
    @(negedge clock);
    hz = ex_is_load && (ex_rd != 5'd0) &&
         ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    e_busy  = (m_left > 0);
    e_pause = 1'b0;
    e_start = 1'b0;
    if (reset)           e_pause = 1'b0;
    else if (m_left > 0) e_pause = 1'b1;
    else if (m_rel)      e_pause = 1'b0;
    else if (hz)         e_pause = 1'b1;
    else if (id_is_mdu) begin e_pause = 1'b1; e_start = 1'b1; end
    e_branch = branch_taken && !e_pause && !reset;

    s_pause = pause; s_bubble = idex_bubble; s_start = mdu_start;
    s_busy = mdu_busy; s_branch = branch_signal;
    chk("pause", pause, e_pause);
    chk("idex_bubble", idex_bubble, e_pause);
    chk("mdu_start", mdu_start, e_start);
    chk("mdu_busy", mdu_busy, e_busy);
    chk("branch_signal", branch_signal, e_branch);
    chk("stall_cycles", stall_cycles, sat(m_stall, 255));
    chk("flush_count", flush_count, sat(m_flush, 255));
    chk("w3_pause", s3_pause, e_pause);
    chk("w3_stall_cycles", s3_stall, sat(m_stall, 7));
    chk("w3_flush_count", s3_flush, sat(m_flush, 7));

    @(posedge clock);
    if (reset) begin
      m_left = 0; m_rel = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (e_start) m_left = MDU - 1;
      else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_rel = 1'b1;
      end else m_rel = 1'b0;
      m_stall += int'(e_pause);
      m_flush += int'(e_branch);
    end
    #1;
  endtask

  initial begin
    clear();
    reset = 1'b1;
    step(); step();
    chk("reset_stall", stall_cycles, 0);
    chk("reset_flush", flush_count, 0);
    chk("reset_busy", mdu_busy, 0);
    reset = 1'b0;

    // load-use hazard on r5
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    step();
    chk("lu_pause", s_pause, 1);
    chk("lu_bubble", s_bubble, 1);
    clear(); step();
    chk("lu_after", s_pause, 0);
    chk("lu_stall_cnt", stall_cycles, 1);

    // register zero never hazards
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    step();
    chk("r0_pause", s_pause, 0);
    clear();
    chk("r0_stall_cnt", stall_cycles, 1);

    // MDU issue held through RELEASE
    id_is_mdu = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      pat_p[i] = s_pause; pat_s[i] = s_start; pat_b[i] = s_busy;
    end
    clear();
    chk("mdu_pause_pat", pat_p, 5'b01111);
    chk("mdu_start_pat", pat_s, 5'b00001);
    chk("mdu_busy_pat", pat_b, 5'b01110);
    chk("mdu_stall_cnt", stall_cycles, 5);

    // unstalled branch
    branch_taken = 1'b1; step();
    chk("br_flush", s_branch, 1);
    clear(); step();
    chk("br_flush_cnt", flush_count, 1);

    // branch behind a load-use stall
    branch_taken = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
    step();
    chk("br_lu_stall", s_branch, 0);
    chk("br_lu_pause", s_pause, 1);
    ex_is_load = 1'b0; step();
    chk("br_lu_next", s_branch, 1);
    clear(); step();
    chk("br_lu_flush_cnt", flush_count, 2);
    chk("br_lu_stall_cnt", stall_cycles, 6);

    // reset in the second MDU_WAIT cycle
    id_is_mdu = 1'b1; step(); step();
    reset = 1'b1; step();
    chk("rst_mdu_pause", s_pause, 0);
    reset = 1'b0; clear(); step();
    chk("rst_mdu_busy", s_busy, 0);
    chk("rst_mdu_after", s_pause, 0);
    chk("rst_mdu_stall", stall_cycles, 0);
    chk("rst_mdu_flush", flush_count, 0);

    // saturation of the 3-bit counter
    ex_is_load = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
    repeat (10) step();
    clear();
    chk("sat3_stall", s3_stall, 7);
    chk("sat8_stall", stall_cycles, 10);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      rand_inputs();
      step();
    end
    reset = 1'b0; clear(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
